serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port start  input  1  request to add a and b, sampled on the rising clk edge.
REQ-005 The block SHALL have port a  input  WIDTH  first operand, captured when start is accepted.
REQ-006 The block SHALL have port b  input  WIDTH  second operand, captured when start is accepted.
REQ-007 The block SHALL have port ready  output  1  high when a start will be accepted (state IDLE or DONE).
REQ-008 The block SHALL have port busy  output  1  high while bits are being added (state SHIFT).
REQ-009 The block SHALL have port done  output  1  single-cycle pulse marking a valid result.
REQ-010 The block SHALL have port sum  output  WIDTH  result bits, LSB-first assembled.
REQ-011 The block SHALL have port carry_out  output  1  final carry of the addition.

Function
REQ-012 The block SHALL implement the three states IDLE, SHIFT and DONE.
REQ-013 In IDLE or DONE, start=1 SHALL load a and b into shift registers, clear the carry flop, clear the bit counter and enter SHIFT.
REQ-014 In DONE with start=0, the block SHALL return to IDLE after one cycle.
REQ-015 Each SHIFT cycle SHALL add operand LSBs plus the carry flop in one full-adder bit, shift the result bit into sum MSB-first-position (right shift), update the carry flop and increment the counter.
REQ-016 After exactly WIDTH SHIFT cycles the block SHALL enter DONE; if start was sampled on edge n, done SHALL be high only between edges n+WIDTH and n+WIDTH+1.
REQ-017 sum and carry_out SHALL equal (a+b) mod 2^WIDTH and bit WIDTH of a+b (zero-extended) while done=1, and SHALL hold that value until the next accepted start.
REQ-018 start while busy=1 SHALL be ignored, with no effect on operands, counter or result.
REQ-019 sum and carry_out SHALL be undefined-free but are not guaranteed meaningful while busy=1.
REQ-020 ready SHALL equal NOT busy at all times; busy and done SHALL never be high together.
REQ-021 The bit counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL never wrap within one operation.

Reset
REQ-022 rst=1 SHALL immediately force state IDLE, ready=1, busy=0, done=0, sum=0, carry_out=0, counter=0, carry flop=0, operand registers=0.
REQ-023 rst asserted mid-operation SHALL abort it with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Structure
REQ-024 State encodings (IDLE=0, SHIFT=1, DONE=2) SHALL live in a shared include file serial_adder_defs.vh.
REQ-025 The per-bit add SHALL be a combinational sub-module full_adder_bit (inputs x, y, cin; outputs s, cout) built from two half-adder stages and an OR.

Verification
REQ-026 WIDTH=8, after reset: a=0x00, b=0x00, start one cycle -> done at edge n+8, sum=0x00, carry_out=0.
REQ-027 a=0xFF, b=0x01 -> sum=0x00, carry_out=1, busy high for exactly 8 cycles.
REQ-028 a=0xA5, b=0x5A -> sum=0xFF, carry_out=0; then start with a=0x01, b=0x01 held two cycles during busy -> second pulse ignored, result stays 0xFF until one done.
REQ-029 start a=0x80, b=0x80, assert rst at cycle 4 -> all outputs 0 immediately, no done pulse; new start a=0x03, b=0x04 -> sum=0x07.
REQ-030 start asserted in the DONE cycle with a=0x10, b=0x20 -> accepted, busy next cycle, sum=0x30 after 8 further cycles.
REQ-031 Randomised 1000 operand pairs, WIDTH=8 and WIDTH=16 -> every result matches a+b reference model.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

`include "serial_adder_defs.vh"

    // Controller states; values come from the shared include file.
    typedef enum logic [1:0] {
        ST_IDLE  = `SA_STATE_IDLE,
        ST_SHIFT = `SA_STATE_SHIFT,
        ST_DONE  = `SA_STATE_DONE
    } sa_state_t;

    // Bit counter width: one extra bit so the count never wraps in an operation.
    function automatic int cnt_bits(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder built from two half-adder stages joined by an OR.
module full_adder_bit (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ha0_sum_s;
    logic ha0_carry_s;
    logic ha1_carry_s;

    // First half adder: operand bits.
    assign ha0_sum_s   = x ^ y;
    assign ha0_carry_s = x & y;

    // Second half adder: partial sum plus incoming carry.
    assign s           = ha0_sum_s ^ cin;
    assign ha1_carry_s = ha0_sum_s & cin;

    // A carry from either stage propagates out.
    assign cout        = ha0_carry_s | ha1_carry_s;

endmodule

// File: rtl/serial_adder_defs.vh
// State encodings shared by the serial adder package and anything else that
// needs to recognise the adder's state values.
`ifndef SERIAL_ADDER_DEFS_VH
`define SERIAL_ADDER_DEFS_VH

`define SA_STATE_IDLE  2'd0
`define SA_STATE_SHIFT 2'd1
`define SA_STATE_DONE  2'd2

`endif

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands one bit per clock, LSB first,
// and reports the result with a single-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CNT_W = cnt_bits(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    sa_state_t        state_r;
    sa_state_t        state_nxt_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] a_nxt_s;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] b_nxt_s;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] sum_nxt_s;
    logic             carry_r;
    logic             carry_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic             bit_sum_s;
    logic             bit_carry_s;

    full_adder_bit u_full_adder_bit (
        .x    (a_r[0]),
        .y    (b_r[0]),
        .cin  (carry_r),
        .s    (bit_sum_s),
        .cout (bit_carry_s)
    );

    // Next-state and datapath update; everything holds unless the state says otherwise.
    always_comb begin
        state_nxt_s = state_r;
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        sum_nxt_s   = sum_r;
        carry_nxt_s = carry_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_nxt_s     = a;
                    b_nxt_s     = b;
                    carry_nxt_s = 1'b0;
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Result bits enter at the MSB and walk down, so the first bit ends at bit 0.
                sum_nxt_s   = {bit_sum_s, sum_r[WIDTH-1:1]};
                a_nxt_s     = {1'b0, a_r[WIDTH-1:1]};
                b_nxt_s     = {1'b0, b_r[WIDTH-1:1]};
                carry_nxt_s = bit_carry_s;
                cnt_nxt_s   = cnt_r + CNT_ONE;
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and status flops; status outputs are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            a_r     <= a_nxt_s;
            b_r     <= b_nxt_s;
            sum_r   <= sum_nxt_s;
            carry_r <= carry_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ready_r <= (state_nxt_s != ST_SHIFT);
            busy_r  <= (state_nxt_s == ST_SHIFT);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    assign ready     = ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign sum       = sum_r;
    assign carry_out = carry_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16.
module tb_serial_adder;

    logic        clk;
    logic        rst;
    logic [1:0]  st;
    logic [31:0] av [2];
    logic [31:0] bv [2];
    logic [1:0]  rdy;
    logic [1:0]  bsy;
    logic [1:0]  dn;
    logic [1:0]  co;
    logic [7:0]  sum8;
    logic [15:0] sum16;

    int vectors = 0;
    int misc    = 0;
    bit chk_en  = 1'b0;

    // model: edge count, edge at which each unit accepted its last start, expected result
    int          ecount = 0;
    int          acc [2] = '{-1, -1};
    logic [31:0] exp_sum [2] = '{32'd0, 32'd0};
    logic        exp_co  [2] = '{1'b0, 1'b0};

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(st[0]), .a(av[0][7:0]), .b(bv[0][7:0]),
        .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .sum(sum8), .carry_out(co[0])
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(st[1]), .a(av[1][15:0]), .b(bv[1][15:0]),
        .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .sum(sum16), .carry_out(co[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int wd(input int i);
        return (i == 0) ? 8 : 16;
    endfunction

    function automatic logic [31:0] dsum(input int i);
        return (i == 0) ? {24'd0, sum8} : {16'd0, sum16};
    endfunction

    // unit i is adding during the cycle that follows edge k
    function automatic bit busy_at(input int i, input int k);
        return (acc[i] >= 0) && (k >= acc[i]) && (k <= acc[i] + wd(i) - 1);
    endfunction

    function automatic longint ref_total(input int i);
        longint m;
        m = (64'd1 << wd(i)) - 64'd1;
        return (longint'(av[i]) & m) + (longint'(bv[i]) & m);
    endfunction

    function automatic logic [31:0] ref_sum(input int i);
        longint m;
        m = (64'd1 << wd(i)) - 64'd1;
        return 32'(ref_total(i) & m);
    endfunction

    function automatic logic ref_co(input int i);
        return ((ref_total(i) >> wd(i)) & 64'd1) != 64'd0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            misc++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // reference model: accept a start only when the unit is not adding
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                acc[i]     <= -1;
                exp_sum[i] <= 32'd0;
                exp_co[i]  <= 1'b0;
            end
        end else begin
            ecount <= ecount + 1;
            for (int i = 0; i < 2; i++) begin
                if (st[i] && !busy_at(i, ecount)) begin
                    acc[i]     <= ecount + 1;
                    exp_sum[i] <= ref_sum(i);
                    exp_co[i]  <= ref_co(i);
                end
            end
        end
    end

    // compare every cycle against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                bit eb;
                eb = busy_at(i, ecount);
                chk($sformatf("w%0d_busy", wd(i)), {31'd0, bsy[i]}, {31'd0, eb});
                chk($sformatf("w%0d_ready", wd(i)), {31'd0, rdy[i]}, {31'd0, !eb});
                chk($sformatf("w%0d_done", wd(i)), {31'd0, dn[i]},
                    {31'd0, (acc[i] >= 0) && (ecount == acc[i] + wd(i))});
                if (!eb) begin
                    chk($sformatf("w%0d_sum", wd(i)), dsum(i), exp_sum[i]);
                    chk($sformatf("w%0d_carry", wd(i)), {31'd0, co[i]}, {31'd0, exp_co[i]});
                end
            end
        end
    end

    // one operation: drive start for one cycle, wait (bounded) for done
    task automatic run_op(input int i, input logic [31:0] x, input logic [31:0] y,
                          input bit immediate, output int lat, output int nbusy);
        if (!immediate) @(negedge clk);
        av[i] = x;
        bv[i] = y;
        st[i] = 1'b1;
        lat   = -1;
        nbusy = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) st[i] = 1'b0;
            if (bsy[i]) nbusy++;
            if (dn[i]) begin
                lat = k - 1;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nb;
        int nd;
        int dk;
        rst   = 1'b1;
        st    = 2'b00;
        av[0] = 32'd0; av[1] = 32'd0;
        bv[0] = 32'd0; bv[1] = 32'd0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_ready", {31'd0, rdy[0]}, 32'd1);
        chk("rst_sum", {24'd0, sum8}, 32'h00);
        rst = 1'b0;

        // 0 + 0
        run_op(0, 32'h00, 32'h00, 1'b0, lat, nb);
        chk("zero_lat", lat, 32'd8);
        chk("zero_sum", {24'd0, sum8}, 32'h00);
        chk("zero_co", {31'd0, co[0]}, 32'd0);

        // FF + 01 wraps with carry, busy exactly 8 cycles
        run_op(0, 32'hFF, 32'h01, 1'b0, lat, nb);
        chk("ff01_sum", {24'd0, sum8}, 32'h00);
        chk("ff01_co", {31'd0, co[0]}, 32'd1);
        chk("ff01_busy_cycles", nb, 32'd8);

        // A5 + 5A
        run_op(0, 32'hA5, 32'h5A, 1'b0, lat, nb);
        chk("a55a_sum", {24'd0, sum8}, 32'hFF);
        chk("a55a_co", {31'd0, co[0]}, 32'd0);

        // start held two cycles: the second sample falls in busy and is ignored
        @(negedge clk);
        av[0] = 32'h01; bv[0] = 32'h01; st[0] = 1'b1;
        @(negedge clk);
        chk("dbl_busy", {31'd0, bsy[0]}, 32'd1);
        @(negedge clk);
        st[0] = 1'b0;
        nd = 0;
        dk = -1;
        for (int k = 3; k <= 30; k++) begin
            @(negedge clk);
            if (dn[0]) begin
                nd++;
                if (dk < 0) begin
                    dk = k;
                    chk("dbl_sum", {24'd0, sum8}, 32'h02);
                end
            end
        end
        chk("dbl_done_count", nd, 32'd1);
        chk("dbl_done_edge", dk, 32'd9);

        // reset in the middle of 80 + 80
        @(negedge clk);
        av[0] = 32'h80; bv[0] = 32'h80; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_ready", {31'd0, rdy[0]}, 32'd1);
        chk("abort_busy", {31'd0, bsy[0]}, 32'd0);
        chk("abort_done", {31'd0, dn[0]}, 32'd0);
        chk("abort_sum", {24'd0, sum8}, 32'h00);
        chk("abort_co", {31'd0, co[0]}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (dn[0]) nd++;
        end
        chk("abort_no_done", nd, 32'd0);
        run_op(0, 32'h03, 32'h04, 1'b0, lat, nb);
        chk("after_rst_sum", {24'd0, sum8}, 32'h07);

        // start in the DONE cycle
        run_op(0, 32'h10, 32'h20, 1'b1, lat, nb);
        chk("done_start_lat", lat, 32'd8);
        chk("done_start_sum", {24'd0, sum8}, 32'h30);

        // wide instance boundary
        run_op(1, 32'hFFFF, 32'h0001, 1'b0, lat, nb);
        chk("w16_lat", lat, 32'd16);
        chk("w16_sum", {16'd0, sum16}, 32'h0000);
        chk("w16_co", {31'd0, co[1]}, 32'd1);

        // random operand pairs, some started straight from DONE
        for (int n = 0; n < 1000; n++) begin
            run_op(0, $urandom & 32'hFF, $urandom & 32'hFF, (n % 3) == 0, lat, nb);
        end
        for (int n = 0; n < 1000; n++) begin
            run_op(1, $urandom & 32'hFFFF, $urandom & 32'hFFFF, (n % 3) == 0, lat, nb);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
